// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Latency: none, declarations only.
// Backpressure: not applicable.
package sub_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell computing a - b - bin.
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first; optional Overflow output with SERIAL_SUBTRACTOR_OVF_EN.
// Latency: Done is high in the cycle closed by edge WIDTH+1 after the accepting edge; throughput WIDTH+2.
// Backpressure: Start is ignored while Busy is high; there is no output stall.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             bw;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .bin  (bw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != IDLE);
        Done = (state == DONE);
    end

    // Operands shift right with sign fill so the MSB stays visible for overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a     <= '0;
            sh_b     <= '0;
            bw       <= 1'b0;
            cnt      <= '0;
            Diff     <= '0;
            Borrow   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            Overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        sh_a <= A;
                        sh_b <= B;
                        bw   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    sh_a <= {sh_a[WIDTH-1], sh_a[WIDTH-1:1]};
                    sh_b <= {sh_b[WIDTH-1], sh_b[WIDTH-1:1]};
                    bw   <= cell_bout;
                    cnt  <= cnt + CW'(1);
                    Diff <= {cell_d, Diff[WIDTH-1:1]};
                    if (last_bit) begin
                        Borrow   <= cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        Overflow <= (sh_a[WIDTH-1] ^ sh_b[WIDTH-1]) &
                                    (sh_a[WIDTH-1] ^ cell_d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8; a cycle model tracks the
// FSM phase and expected results are queued on acceptance, popped at DONE.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Diff;
    logic         Borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         Overflow;
`endif

    int checks = 0;
    int errors = 0;

    exp_t         q[$];
    exp_t         e;
    int           m_phase = 0;
    logic [W-1:0] m_diff = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf = 1'b0;
    bit           started = 1'b0;
    int           n_done = 0;
    int           n_exp = 0;
    int           snap;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .Diff     (Diff),
        .Borrow   (Borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .Overflow (Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       r;
        logic [W:0] t;
        int         s;
        t        = {1'b0, a} - {1'b0, b};
        r.diff   = t[W-1:0];
        r.borrow = t[W];
        s        = int'($signed(a)) - int'($signed(b));
        r.ovf    = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        return r;
    endfunction

    // Phase 1..W is RUN, W+1 is DONE, 0 is IDLE.
    always @(posedge clk) begin
        if (rst) begin
            started  <= 1'b1;
            m_phase  <= 0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_ovf    <= 1'b0;
            q.delete();
        end else if (started) begin
            if (m_phase == 0) begin
                if (Start) begin
                    q.push_back(mk(A, B));
                    m_phase <= 1;
                end
            end else if (m_phase == W) begin
                e         = q.pop_front();
                m_diff   <= e.diff;
                m_borrow <= e.borrow;
                m_ovf    <= e.ovf;
                n_exp    <= n_exp + 1;
                m_phase  <= W + 1;
            end else if (m_phase == W + 1) begin
                m_phase <= 0;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", Busy, m_phase != 0);
            chk("done", Done, m_phase == W + 1);
            if (Done) n_done++;
            if (m_phase == 0 || m_phase == W + 1) chk("diff", Diff, m_diff);
            chk("borrow", Borrow, m_borrow);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            chk("overflow", Overflow, m_ovf);
`endif
        end
    end

    // Leaves the bench at the negedge inside DONE, so the next op is back-to-back.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        @(negedge clk);
        Start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        repeat (W) begin
            if (scramble) begin
                A = W'($urandom);
                B = W'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic op_reset_at(input logic [W-1:0] a, input logic [W-1:0] b, input int run_cycle);
        @(negedge clk);
        Start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        repeat (run_cycle - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        op(8'h0A, 8'h03, 1'b0);
        op(8'h03, 8'h0A, 1'b0);
        op(8'h80, 8'h01, 1'b0);
        op(8'h00, 8'h00, 1'b0);
        op(8'hFF, 8'hFF, 1'b0);
        op(8'h00, 8'hFF, 1'b0);
        op(8'h7F, 8'h80, 1'b0);
        op(8'h01, 8'h02, 1'b0);
        for (int i = 0; i < 12; i++) op(W'($urandom), W'($urandom), 1'b1);

        // Start held high with changing operands: one accept every W+2 cycles.
        #1 snap = n_done;
        @(negedge clk);
        Start = 1'b1;
        repeat (5 * (W + 2)) begin
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
        end
        Start = 1'b0;
        #1 chk("burst_dones", n_done - snap, 5);
        repeat (W + 2) @(negedge clk);

        // Abort on the 4th RUN cycle after a borrowing result is held.
        op(8'h03, 8'h0A, 1'b0);
        op_reset_at(8'h55, 8'h22, 4);
        op(8'h55, 8'h22, 1'b0);

        // Abort on the last RUN cycle: the DONE edge never arrives.
        op_reset_at(8'h10, 8'h20, W);
        op(8'h10, 8'h20, 1'b0);

        // Reset wins over Start on the same edge.
        @(negedge clk);
        rst   = 1'b1;
        Start = 1'b1;
        A     = 8'h44;
        B     = 8'h11;
        @(negedge clk);
        rst   = 1'b0;
        Start = 1'b0;
        repeat (2) @(negedge clk);
        op(8'hC3, 8'h3C, 1'b1);

        repeat (3) @(negedge clk);
        #1 chk("done_count", n_done, n_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
